// File: rtl/rq0_unpack_stream.sv
// rq0_unpack_stream: unpacks a packed Rq polynomial into 13-bit coefficients.
// Input arrives as 32-bit little-endian words. One byte per cycle moves into a
// 20-bit bit accumulator, and one 13-bit coefficient per cycle is taken from it.
// After the N-1 packed coefficients, the block emits the reconstructed last
// coefficient, (-sum) mod 2^13.
module rq0_unpack_stream (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] in_word,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [12:0] coef_out,
  output logic        coef_valid,
  input  logic        coef_ready,
  output logic        coef_last,
  output logic        busy,
  output logic        done
);

  localparam int unsigned N      = 701;
  localparam int unsigned LOG_Q  = 13;
  localparam int unsigned WORDS  = 285;
  localparam int unsigned NPACK  = N - 1;
  localparam int unsigned ACC_W  = 20;
  localparam int unsigned WCNT_W = 9;
  localparam int unsigned CCNT_W = 10;
  localparam int unsigned BCNT_W = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_LAST = 2'd2
  } state_t;

  state_t              state, state_n;
  logic [31:0]         wreg, wreg_n;
  logic                wfull, wfull_n;
  logic [1:0]          bptr, bptr_n;
  logic [WCNT_W-1:0]   wcnt, wcnt_n;
  logic [ACC_W-1:0]    acc, acc_n;
  logic [BCNT_W-1:0]   bit_cnt, bit_cnt_n;
  logic [CCNT_W-1:0]   coef_cnt, coef_cnt_n;
  logic [LOG_Q-1:0]    sum, sum_n;
  logic                in_ready_n;
  logic [LOG_Q-1:0]    coef_out_n;
  logic                coef_valid_n;
  logic                coef_last_n;
  logic                busy_n;
  logic                done_n;

  logic                word_take;
  logic                coef_hs;
  logic                ext;
  logic                ins;
  logic [7:0]          sel_byte;

  // State and output registers; reset aborts any operation in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      wreg       <= '0;
      wfull      <= 1'b0;
      bptr       <= '0;
      wcnt       <= '0;
      acc        <= '0;
      bit_cnt    <= '0;
      coef_cnt   <= '0;
      sum        <= '0;
      in_ready   <= 1'b0;
      coef_out   <= '0;
      coef_valid <= 1'b0;
      coef_last  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      wreg       <= wreg_n;
      wfull      <= wfull_n;
      bptr       <= bptr_n;
      wcnt       <= wcnt_n;
      acc        <= acc_n;
      bit_cnt    <= bit_cnt_n;
      coef_cnt   <= coef_cnt_n;
      sum        <= sum_n;
      in_ready   <= in_ready_n;
      coef_out   <= coef_out_n;
      coef_valid <= coef_valid_n;
      coef_last  <= coef_last_n;
      busy       <= busy_n;
      done       <= done_n;
    end
  end

  // Next-state logic: word load, byte insert, coefficient extraction, phase changes
  always_comb begin
    state_n      = state;
    wreg_n       = wreg;
    wfull_n      = wfull;
    bptr_n       = bptr;
    wcnt_n       = wcnt;
    acc_n        = acc;
    bit_cnt_n    = bit_cnt;
    coef_cnt_n   = coef_cnt;
    sum_n        = sum;
    coef_out_n   = coef_out;
    coef_valid_n = coef_valid;
    coef_last_n  = coef_last;
    done_n       = 1'b0;

    word_take = in_valid & in_ready;
    coef_hs   = coef_valid & coef_ready;
    sel_byte  = wreg[{bptr, 3'b000} +: 8];
    // Extraction stops after the last packed coefficient; any leftover bits are dropped
    ext = (state == S_RUN) && (bit_cnt >= BCNT_W'(LOG_Q)) &&
          (!coef_valid || coef_ready) && (coef_cnt < CCNT_W'(NPACK));
    ins = (state == S_RUN) && wfull && ((bit_cnt < BCNT_W'(LOG_Q)) || ext);

    case (state)
      S_IDLE: begin
        if (start) begin
          state_n    = S_RUN;
          wfull_n    = 1'b0;
          bptr_n     = '0;
          wcnt_n     = '0;
          acc_n      = '0;
          bit_cnt_n  = '0;
          coef_cnt_n = '0;
          sum_n      = '0;
        end
      end
      S_RUN: begin
        if (word_take) begin
          wreg_n  = in_word;
          wfull_n = 1'b1;
          bptr_n  = '0;
          wcnt_n  = wcnt + WCNT_W'(1);
        end
        if (coef_hs) begin
          coef_valid_n = 1'b0;
        end
        if (ext) begin
          coef_out_n   = acc[LOG_Q-1:0];
          coef_valid_n = 1'b1;
          acc_n        = acc >> LOG_Q;
          bit_cnt_n    = bit_cnt - BCNT_W'(LOG_Q);
          sum_n        = sum + acc[LOG_Q-1:0];
          coef_cnt_n   = coef_cnt + CCNT_W'(1);
        end
        if (ins) begin
          acc_n     = acc_n | (ACC_W'(sel_byte) << bit_cnt_n);
          bit_cnt_n = bit_cnt_n + BCNT_W'(8);
          bptr_n    = bptr + 2'd1;
          if (bptr == 2'd3) begin
            wfull_n = 1'b0;
          end
        end
        // Last packed coefficient accepted: load the reconstructed one in the same cycle
        if (coef_hs && (coef_cnt == CCNT_W'(NPACK))) begin
          state_n      = S_LAST;
          wfull_n      = 1'b0;
          acc_n        = '0;
          bit_cnt_n    = '0;
          coef_out_n   = LOG_Q'(0) - sum;
          coef_valid_n = 1'b1;
          coef_last_n  = 1'b1;
        end
      end
      S_LAST: begin
        if (coef_hs) begin
          state_n      = S_IDLE;
          coef_valid_n = 1'b0;
          coef_last_n  = 1'b0;
          done_n       = 1'b1;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    busy_n     = (state_n != S_IDLE);
    in_ready_n = (state_n == S_RUN) && !wfull_n && (wcnt_n < WCNT_W'(WORDS));
  end

endmodule

// File: tb/tb_rq0_unpack_stream.sv
// Testbench for rq0_unpack_stream. Each row of a table describes one run:
// the data pattern, the stall rates, an optional start pulse while busy or a
// reset mid-run, and the expected last coefficient. The reference packs
// coefficients into a bit array and expects the same list back, followed by
// (-sum) mod 8192.
module tb_rq0_unpack_stream;

  localparam int NP    = 700;
  localparam int NW    = 285;
  localparam int BUDGET = 20000;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] in_word;
  logic        in_valid;
  logic        in_ready;
  logic [12:0] coef_out;
  logic        coef_valid;
  logic        coef_ready;
  logic        coef_last;
  logic        busy;
  logic        done;

  int vectors;
  int miscompares;

  rq0_unpack_stream dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_word    (in_word),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .coef_out   (coef_out),
    .coef_valid (coef_valid),
    .coef_ready (coef_ready),
    .coef_last  (coef_last),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int mode;       // 0 zeros, 1 all ones, 2 ramp 1..700, 3 random
    int rdy_pct;
    int vld_pct;
    int start_at;   // coefficient index at which start is pulsed (-1 none)
    int abort_at;   // coefficient index at which reset is applied (-1 none)
    int exp_last;   // expected last coefficient (-1: use reference model)
    bit timing;     // check startup latency
  } row_t;

  row_t rows[8];

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, int'(in_ready), 0);
    check({tag, "_coef_out"}, int'(coef_out), 0);
    check({tag, "_coef_valid"}, int'(coef_valid), 0);
    check({tag, "_coef_last"}, int'(coef_last), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
  endtask

  task automatic run(input row_t r);
    logic [12:0] coefs[NP];
    logic [31:0] words[NW];
    bit          pbits[NW*32];
    int          sum, exp_last, k, wt, c, done_cnt, done_cyc, last_hs_cyc;
    int          first_ready, first_valid, exp_v;
    bit          finished, held, held_last, aborted, start_pulsed;
    logic [12:0] held_out;

    // build coefficients and the packed word stream
    sum = 0;
    for (int i = 0; i < NP; i++) begin
      case (r.mode)
        0: coefs[i] = 13'd0;
        1: coefs[i] = 13'h1fff;
        2: coefs[i] = 13'(i + 1);
        default: coefs[i] = 13'($urandom_range(8191));
      endcase
      sum += int'(coefs[i]);
    end
    for (int b = 0; b < NW*32; b++) pbits[b] = 1'b0;
    for (int i = 0; i < NP; i++)
      for (int j = 0; j < 13; j++) pbits[i*13 + j] = coefs[i][j];
    for (int w = 0; w < NW; w++)
      for (int b = 0; b < 32; b++) words[w][b] = pbits[w*32 + b];
    exp_last = (r.exp_last >= 0) ? r.exp_last : ((8192 - (sum % 8192)) % 8192);

    k = 0; wt = 0; c = 0; done_cnt = 0; done_cyc = -1; last_hs_cyc = -1;
    first_ready = -1; first_valid = -1;
    finished = 0; held = 0; held_last = 0; held_out = '0; aborted = 0; start_pulsed = 0;

    @(posedge clk); #1;
    start      = 1'b1;
    in_valid   = ($urandom_range(99) < r.vld_pct);
    in_word    = words[0];
    coef_ready = ($urandom_range(99) < r.rdy_pct);

    while (!finished && c < BUDGET) begin
      @(negedge clk);
      if (first_ready < 0 && in_ready) first_ready = c;
      if (first_valid < 0 && coef_valid) first_valid = c;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
        finished = 1;
      end
      if (held) begin
        check("stall_hold", {31'(coef_valid), 13'(coef_out), 1'(coef_last)} == {31'd1, held_out, held_last} ? 1 : 0, 1);
      end
      held      = coef_valid && !coef_ready;
      held_out  = coef_out;
      held_last = coef_last;
      if (in_valid && in_ready) wt++;
      if (coef_valid && coef_ready) begin
        if (k < NP) begin
          check($sformatf("coef[%0d]", k), int'(coef_out), int'(coefs[k]));
          check($sformatf("last_flag[%0d]", k), int'(coef_last), 0);
        end else if (k == NP) begin
          check("coef_last_value", int'(coef_out), exp_last);
          check("coef_last_flag", int'(coef_last), 1);
          last_hs_cyc = c;
        end else begin
          check("extra_coef", k, NP);
        end
        k++;
      end

      @(posedge clk); #1;
      c++;
      start = 1'b0;
      if (r.start_at >= 0 && k == r.start_at && !start_pulsed) begin
        start = 1'b1;
        start_pulsed = 1;
      end
      in_valid   = ($urandom_range(99) < r.vld_pct);
      in_word    = (wt < NW) ? words[wt] : 32'd0;
      coef_ready = ($urandom_range(99) < r.rdy_pct);
      if (r.abort_at >= 0 && k == r.abort_at) begin
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        start    = 1'b0;
        in_valid = 1'b0;
        coef_ready = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        check_reset_outputs("abort_held");
        rst_n = 1'b1;
        aborted = 1;
        finished = 1;
      end
    end

    if (!aborted) begin
      check("run_finished", int'(finished), 1);
      check("coef_count", k, NP + 1);
      check("words_taken", wt, NW);
      check("done_after_last_hs", done_cyc, last_hs_cyc + 1);
      in_valid   = 1'b0;
      coef_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        if (done) done_cnt++;
      end
      check("done_pulses", done_cnt, 1);
      check("idle_busy", int'(busy), 0);
      check("idle_in_ready", int'(in_ready), 0);
      if (r.timing) begin
        check("first_in_ready_cycle", first_ready, 1);
        check("first_coef_valid_cycle", first_valid, 5);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    start       = 1'b0;
    in_word     = 32'd0;
    in_valid    = 1'b0;
    coef_ready  = 1'b0;

    rows[0] = '{mode:0, rdy_pct:100, vld_pct:100, start_at:-1,  abort_at:-1,  exp_last:0,   timing:1'b1};
    rows[1] = '{mode:1, rdy_pct:100, vld_pct:100, start_at:-1,  abort_at:-1,  exp_last:700, timing:1'b1};
    rows[2] = '{mode:2, rdy_pct:100, vld_pct:100, start_at:-1,  abort_at:-1,  exp_last:410, timing:1'b1};
    rows[3] = '{mode:2, rdy_pct:50,  vld_pct:60,  start_at:-1,  abort_at:-1,  exp_last:410, timing:1'b0};
    rows[4] = '{mode:3, rdy_pct:50,  vld_pct:70,  start_at:100, abort_at:-1,  exp_last:-1,  timing:1'b0};
    rows[5] = '{mode:3, rdy_pct:80,  vld_pct:90,  start_at:-1,  abort_at:300, exp_last:-1,  timing:1'b0};
    rows[6] = '{mode:3, rdy_pct:100, vld_pct:100, start_at:-1,  abort_at:-1,  exp_last:-1,  timing:1'b1};
    rows[7] = '{mode:1, rdy_pct:30,  vld_pct:50,  start_at:-1,  abort_at:-1,  exp_last:700, timing:1'b0};

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("post_reset_idle");

    for (int i = 0; i < 8; i++) begin
      run(rows[i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rq0_unpack_stream.md
# rq0_unpack_stream

Streaming unpacker feeding the Rq0 add/unpack unit in the Encaps datapath. Accepts the packed Rq polynomial as 32-bit little-endian words, steps a 2-bit byte pointer to pick one byte per cycle through a 4:1 byte selector, and assembles 13-bit coefficients from a bit accumulator. After the 700 packed coefficients it emits the reconstructed last coefficient, (−Σ) mod 8192, to complete the 701-coefficient Rq0 element.

## Interface
- N, 701, coefficients per polynomial (N−1 are packed)
- LOG_Q, 13, coefficient width
- WORDS, 285, input words per polynomial: ceil(ceil((N−1)·LOG_Q/8)/4)
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle request to unpack one polynomial; honoured only in IDLE
- in_word  in  32  packed word; byte k is in_word[8k+7:8k], consumed k=0 first
- in_valid  in  1  in_word valid
- in_ready  out  1  word register empty and state RUN and fewer than WORDS words taken
- coef_out  out  13  coefficient
- coef_valid  out  1  coef_out valid; held with stable data until coef_ready
- coef_ready  in  1  downstream accepts coef_out
- coef_last  out  1  high with the N-th (reconstructed) coefficient
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse on the cycle after the last coefficient handshake

## Operation
- States: IDLE → RUN on start; RUN → LAST after the (N−1)-th coefficient handshake; LAST → IDLE after the coef_last handshake.
- start in IDLE clears word count, byte pointer, bit accumulator (20 bits) and bit count, coefficient count, and 13-bit running sum. start outside IDLE is ignored.
- Word register: loaded on in_valid & in_ready; byte pointer reset to 0. After byte 3 is inserted, the register is empty.
- Byte insert (at most one per cycle): when word register full and (bit_cnt < 13 or an extraction occurs this cycle). The selected byte goes to accumulator bits [bit_cnt+7:bit_cnt] after any extraction shift. Byte pointer increments modulo 4.
- Extraction (at most one per cycle): in RUN, when bit_cnt ≥ 13 and the output register is empty or handshaking this cycle. coef_out ← acc[12:0], acc >>= 13, bit_cnt −= 13, sum ← (sum + coef) mod 8192.
- Net bit_cnt per cycle is +8, −13, −5, or 0. Its maximum is 20.
- After N−1 coefficients, the 4 leftover bits of the final byte and the 2 unused bytes of word WORDS−1 are discarded. Word register and accumulator are cleared on entering LAST.
- LAST: coef_out ← (8192 − sum) mod 8192 with coef_last = 1, held until coef_ready.
- Reset values: in_ready=0, coef_out=0, coef_valid=0, coef_last=0, busy=0, done=0, state IDLE.
- Reset mid-operation aborts the operation. Partial data is discarded and no done pulse is issued.

## Timing
- With start sampled in cycle S, in_valid held high and coef_ready held high:
  - in_ready=1 in cycle S+1, with word 0 taken at the end of S+1.
  - Bytes 0 and 1 are inserted at the ends of S+2 and S+3.
  - The first coef_valid appears in S+5.
- Input rate is 1 byte/cycle. A new word is accepted the cycle after byte 3 is inserted, giving 1 idle byte slot per word when in_ready is registered.
- A coefficient's handshake and the next coefficient's load occur in the same cycle, so there are no bubbles when data is available.
- coef_out and coef_last must not change while coef_valid=1 and coef_ready=0.
- in_valid gaps stall byte insertion only. Pending extractions still proceed.
- done is high for exactly one cycle, in the cycle IDLE is entered.

## Test plan
- All-zero input (285 words of 0x00000000) → 700 coefficients of 0, then coef_last with 0; done pulses once; exactly 285 words accepted.
- All-0xFF input → 700 coefficients of 8191, then last coefficient 700 (sum ≡ 7492).
- Coefficients 1..700 packed LSB-first → outputs 1..700 in order, then last coefficient 410 (245350 mod 8192 = 7782).
- Random coef_ready (~50%) and random in_valid gaps → identical output sequence to the unstalled run; coef_out stable during every stall.
- Pulse start while busy at coefficient 100 → ignored; run completes normally.
- Deassert rst_n at coefficient 300, then restart → all outputs return to reset values immediately; the next run produces a correct full sequence.
